// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked word load/store responder for a 32-byte big-endian data memory.
// Latency: request accepted at edge E0 -> resp_valid high after edge E0+WAIT_CYCLES+1.
// Backpressure: one transaction in flight; req_ready low from accept until the response handshake.
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Wait-state count as loaded into the 4-bit counter (legal range 0..15).
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-wide storage; deliberately outside the reset domain so contents survive reset.
  logic [7:0] mem [0:31];

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Byte addresses of the addressed word; aligned words never wrap (28 -> 28..31).
  logic [4:0]  b0_d, b1_d, b2_d, b3_d;
  logic        access_d;
  logic        aligned_d;
  logic        mem_we_d;
  logic [31:0] load_word_d;

  // Decode the memory access that happens on the last wait-state edge.
  always_comb begin
    b0_d        = {addr_q[4:2], 2'b00};
    b1_d        = {addr_q[4:2], 2'b01};
    b2_d        = {addr_q[4:2], 2'b10};
    b3_d        = {addr_q[4:2], 2'b11};
    access_d    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    aligned_d   = (addr_q[1:0] == 2'b00);
    mem_we_d    = access_d && wr_q && aligned_d;
    load_word_d = {mem[b0_d], mem[b1_d], mem[b2_d], mem[b3_d]};
  end

  // Big-endian store: most significant byte goes to the lowest address.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[b0_d] <= wdata_q[31:24];
      mem[b1_d] <= wdata_q[23:16];
      mem[b2_d] <= wdata_q[15:8];
      mem[b3_d] <= wdata_q[7:0];
    end
  end

  // Request/wait/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= 5'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= WAIT_LD;
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // The access itself: misaligned requests touch nothing and report an error.
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
            if (!aligned_d) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else if (wr_q) begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'd0;
            end else begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= load_word_d;
            end
          end
        end
        S_RESP: begin
          // Response is held stable until the requester takes it.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
